// File: rtl/adder_io_pkg.sv
// Shared widths, sequencer state encoding and the reference sum used by the
// adder operand sequencer.
package adder_io_pkg;

  localparam int OP_W  = 4;
  localparam int SUM_W = OP_W + 1;

  // Encoding is fixed because it drives the board status LEDs directly.
  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SETTLE = 2'b10,
    SHOW   = 2'b11
  } seq_state_t;

  // Behavioural reference: unsigned zero-extended add, cannot overflow SUM_W.
  function automatic logic [SUM_W-1:0] ref_sum(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce counter that
// restarts whenever the synced level returns to the accepted level, and a
// one-cycle press pulse on the accepted 0->1 transition. Release is silent.
// Raw edge to press pulse latency is 2 + DEBOUNCE_CYCLES clock cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic             level;
  logic [CNT_W-1:0] cnt;

  assign synced = sync_q[1];

  // Bring the asynchronous button into the clock domain.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Accept a new level only after it has differed from the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles; emit a pulse on accepted rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= synced;
        cnt   <= '0;
        press <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Operand front-end and result stage for the lab-board 4-bit adder.
// Captures A then B from the switches on debounced presses, holds them on
// the adder inputs, waits SETTLE_CYCLES, then registers the adder's SUM and
// flags any disagreement with the reference sum. All outputs are registered.
module adder_operand_sequencer
  import adder_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  sw,
  input  logic             btn_load,
  input  logic             clr,
  input  logic [SUM_W-1:0] sum_in,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic [SUM_W-1:0] result,
  output logic             result_valid,
  output logic             sum_mismatch,
  output logic [1:0]       state_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_load),
    .press  (press)
  );

  // state is itself a register, so the LED status output stays registered.
  assign state_o = state;

  // Sequencer: operand capture, settle wait, result sampling; clr overrides
  // everything and discards a coincident press.
  // NOTE: every register here, settle counter included, is cleared by the
  // async reset so the board comes up in a known state without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_A;
      settle_cnt   <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      sum_mismatch <= 1'b0;
    end else if (clr) begin
      // result deliberately keeps its last value for the display.
      state        <= WAIT_A;
      settle_cnt   <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result_valid <= 1'b0;
      sum_mismatch <= 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (press) begin
            op_a  <= sw;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (press) begin
            op_b       <= sw;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Presses are ignored while the adder settles.
          if (settle_cnt == SETTLE_LAST) begin
            result       <= sum_in;
            sum_mismatch <= (sum_in != ref_sum(op_a, op_b));
            result_valid <= 1'b1;
            state        <= SHOW;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SHOW: begin
          // Chained operation: new A, old B stays on the adder until recaptured.
          if (press) begin
            result_valid <= 1'b0;
            sum_mismatch <= 1'b0;
            op_a         <= sw;
            state        <= WAIT_B;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule
